// File: rtl/lexer.sv
// Tokenizer feeding the LR parser: turns an ASCII byte stream into 16-bit
// {6'b0, kind, value} tokens, holding each until the parser's RECEIVE pulse.
module lexer #(
  parameter logic [1:0] KIND_NUM  = 2'd0,
  parameter logic [1:0] KIND_PLUS = 2'd1,
  parameter logic [1:0] KIND_STAR = 2'd2,
  parameter logic [1:0] KIND_EOF  = 2'd3,
  parameter bit         SAT_NUM   = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_VALID,
  input  logic [7:0]  I_CHAR,
  output logic        I_READY,
  output logic        O_VALID,
  output logic [15:0] O_TOKEN,
  input  logic        I_RECEIVE,
  output logic        ERROR
);

  typedef enum logic [2:0] {S_IDLE, S_NUM, S_PEND, S_DONE, S_ERROR} state_e;
  typedef enum logic [2:0] {C_DIGIT, C_OP, C_WS, C_NUL, C_ILL} class_e;

  localparam logic [15:0] EOF_TOKEN = {6'b0, KIND_EOF, 8'h00};

  function automatic class_e classify(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)                           return C_DIGIT;
    if (c == 8'h2B || c == 8'h2A)                           return C_OP;
    if (c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D) return C_WS;
    if (c == 8'h00)                                         return C_NUL;
    return C_ILL;
  endfunction

  function automatic logic [15:0] op_token(input logic [7:0] c);
    return {6'b0, (c == 8'h2B) ? KIND_PLUS : KIND_STAR, 8'h00};
  endfunction

  state_e      state_q;
  logic [7:0]  acc_q;
  logic [7:0]  acc_d;
  logic [7:0]  pend_q;
  logic        valid_q;
  logic [15:0] token_q;
  logic        error_q;
  logic [11:0] prod;
  logic        accept;
  class_e      in_class;
  class_e      pend_class;

  // 255*10+9 fits in 12 bits, so the clamp test sees the true value.
  always_comb begin
    prod = ({4'b0, acc_q} * 12'd10) + {8'b0, I_CHAR[3:0]};
    if (SAT_NUM && (prod > 12'd255)) acc_d = 8'hFF;
    else                             acc_d = prod[7:0];
  end

  assign in_class   = classify(I_CHAR);
  assign pend_class = classify(pend_q);
  assign I_READY    = RST && (state_q == S_IDLE || state_q == S_NUM) && !valid_q;
  assign accept     = I_VALID && I_READY;
  assign O_VALID    = valid_q;
  assign O_TOKEN    = token_q;
  assign ERROR      = error_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      token_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (valid_q && I_RECEIVE) valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          case (in_class)
            C_DIGIT: begin acc_q <= {4'b0, I_CHAR[3:0]}; state_q <= S_NUM; end
            C_OP:    begin token_q <= op_token(I_CHAR); valid_q <= 1'b1; end
            C_WS:    ;
            C_NUL:   begin token_q <= EOF_TOKEN; valid_q <= 1'b1; state_q <= S_DONE; end
            default: begin error_q <= 1'b1; state_q <= S_ERROR; end
          endcase
        end
        S_NUM: if (accept) begin
          case (in_class)
            C_DIGIT: acc_q <= acc_d;
            C_ILL:   begin error_q <= 1'b1; state_q <= S_ERROR; end
            default: begin
              token_q <= {6'b0, KIND_NUM, acc_q};
              valid_q <= 1'b1;
              pend_q  <= I_CHAR;
              state_q <= S_PEND;
            end
          endcase
        end
        // The char that terminated a number is replayed once the NUM token is gone.
        S_PEND: if (!valid_q) begin
          case (pend_class)
            C_OP:    begin token_q <= op_token(pend_q); valid_q <= 1'b1; state_q <= S_IDLE; end
            C_NUL:   begin token_q <= EOF_TOKEN; valid_q <= 1'b1; state_q <= S_DONE; end
            default: state_q <= S_IDLE;
          endcase
        end
        S_DONE:  ;
        default: valid_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_lexer.sv
// Self-checking bench for lexer: directed scenarios plus random streams scored
// against a string-level tokenizer model, wrap and saturate variants in lockstep.
module tb_lexer;

  typedef logic [7:0]  bq_t[$];
  typedef logic [15:0] tq_t[$];

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        I_VALID = 1'b0;
  logic [7:0]  I_CHAR = 8'h00;
  logic        I_RECEIVE = 1'b0;
  logic        rdy0, vld0, err0, rdy1, vld1, err1;
  logic [15:0] tok0, tok1;

  int checks = 0;
  int failures = 0;
  tq_t got0, got1;

  always #5 CLK = ~CLK;

  lexer #(.SAT_NUM(1'b0)) u_wrap (
    .CLK(CLK), .RST(RST), .I_VALID(I_VALID), .I_CHAR(I_CHAR), .I_READY(rdy0),
    .O_VALID(vld0), .O_TOKEN(tok0), .I_RECEIVE(I_RECEIVE), .ERROR(err0));

  lexer #(.SAT_NUM(1'b1)) u_sat (
    .CLK(CLK), .RST(RST), .I_VALID(I_VALID), .I_CHAR(I_CHAR), .I_READY(rdy1),
    .O_VALID(vld1), .O_TOKEN(tok1), .I_RECEIVE(I_RECEIVE), .ERROR(err1));

  // '~' stands for NUL in the directed strings.
  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back((s[i] == 8'h7E) ? 8'h00 : 8'(s[i]));
    return q;
  endfunction

  function automatic void model(input bq_t q, input bit sat, output tq_t toks, output bit err);
    int wrap = 0, tv = 0;
    bit innum = 0;
    logic [7:0] c;
    toks = {};
    err = 0;
    foreach (q[i]) begin
      c = q[i];
      if (c >= 8'h30 && c <= 8'h39) begin
        wrap = ((innum ? wrap * 10 : 0) + int'(c) - 48) % 256;
        tv   = (innum ? tv * 10 : 0) + int'(c) - 48;
        if (tv > 1000) tv = 1000;
        innum = 1;
        continue;
      end
      if (!(c == 8'h2B || c == 8'h2A || c == 8'h20 || c == 8'h09 ||
            c == 8'h0A || c == 8'h0D || c == 8'h00)) begin
        err = 1;
        break;
      end
      if (innum) begin
        toks.push_back({8'h00, sat ? ((tv > 255) ? 8'hFF : 8'(tv)) : 8'(wrap)});
        innum = 0;
      end
      if (c == 8'h2B)      toks.push_back(16'h0100);
      else if (c == 8'h2A) toks.push_back(16'h0200);
      else if (c == 8'h00) begin toks.push_back(16'h0300); break; end
    end
  endfunction

  function automatic int diff_at(input tq_t a, input tq_t b);
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) return i;
    return (a.size() == b.size()) ? -1 : ((a.size() < b.size()) ? a.size() : b.size());
  endfunction

  task automatic do_reset();
    I_VALID = 1'b0; I_RECEIVE = 1'b0; I_CHAR = 8'h00;
    RST = 1'b1; #1; RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // Feeds q, consumes tokens `delay` cycles after O_VALID rises, and watches the handshake.
  task automatic run(input bq_t q, input int delay, input int budget);
    int idx = 0, vcnt = 0, tail = -1;
    logic recv_prev = 1'b0, held_v = 1'b0;
    logic [15:0] held = '0;
    bit done = 0;
    got0 = {}; got1 = {};
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge CLK);
      checks++;
      if (recv_prev && vld0 !== 1'b0) begin
        failures++; $display("FAIL gap: O_VALID=%b on cycle after receive, want 0", vld0);
      end
      checks++;
      if (vld0 === 1'b1 && rdy0 !== 1'b0) begin
        failures++; $display("FAIL ready_while_valid: I_READY=%b, want 0", rdy0);
      end
      if (held_v && vld0 === 1'b1) begin
        checks++;
        if (tok0 !== held) begin
          failures++; $display("FAIL hold: O_TOKEN=%h, want %h", tok0, held);
        end
      end
      checks++;
      if ({rdy1, vld1, err1} !== {rdy0, vld0, err0}) begin
        failures++; $display("FAIL lockstep: sat rdy/vld/err=%b, wrap=%b", {rdy1, vld1, err1}, {rdy0, vld0, err0});
      end
      if (err0 === 1'b1 && tail < 0) tail = 5;
      if (tail >= 0) begin
        checks++;
        if (rdy0 !== 1'b0 || vld0 !== 1'b0) begin
          failures++; $display("FAIL quiet_after_end: I_READY=%b O_VALID=%b, want 0 0", rdy0, vld0);
        end
        if (tail == 0) done = 1;
        tail--;
      end
      recv_prev = 1'b0;
      I_RECEIVE = 1'b0;
      if (vld0 !== 1'b1) begin
        vcnt = 0; held_v = 1'b0;
      end else if (vcnt == delay) begin
        I_RECEIVE = 1'b1;
        got0.push_back(tok0); got1.push_back(tok1);
        recv_prev = 1'b1; vcnt = 0; held_v = 1'b0;
        if (tok0[9:8] == 2'd3 && tail < 0) tail = 5;
      end else begin
        vcnt++; held = tok0; held_v = 1'b1;
      end
      I_VALID = (idx < q.size()) || (tail >= 0);
      I_CHAR  = (idx < q.size()) ? q[idx] : 8'h37;
      if (I_VALID && rdy0 === 1'b1) idx++;
    end
    @(negedge CLK);
    I_VALID = 1'b0; I_RECEIVE = 1'b0;
    checks++;
    if (!done) begin
      failures++; $display("FAIL timeout: stream not finished after %0d cycles, want EOF or ERROR", budget);
    end
  endtask

  task automatic expect_tokens(input string name, input tq_t got, input tq_t exp);
    int d;
    d = diff_at(got, exp);
    checks++;
    if (d >= 0) begin
      failures++;
      $display("FAIL %s: token[%0d] got=%h (n=%0d), want=%h (n=%0d)", name, d,
               (d < got.size()) ? got[d] : 16'hxxxx, got.size(),
               (d < exp.size()) ? exp[d] : 16'hxxxx, exp.size());
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; #1; RST = 1'b0; #1;
    checks++;
    if ({rdy0, vld0, tok0, err0, rdy1, vld1, tok1, err1} !== '0) begin
      failures++; $display("FAIL reset_outputs: got %b, want all 0", {rdy0, vld0, tok0, err0, rdy1, vld1, tok1, err1});
    end
    @(negedge CLK); RST = 1'b1; #1;
    checks++;
    if ({rdy0, vld0, err0} !== 3'b100) begin
      failures++; $display("FAIL after_reset: rdy/vld/err=%b, want 100", {rdy0, vld0, err0});
    end
  endtask

  task automatic test_expression();
    do_reset();
    run(str2q("12+3*4~"), 2, 200);
    expect_tokens("expr", got0, '{16'h000C, 16'h0100, 16'h0003, 16'h0200, 16'h0004, 16'h0300});
  endtask

  task automatic test_whitespace();
    do_reset();
    run(str2q("  7 ~"), 1, 200);
    expect_tokens("whitespace", got0, '{16'h0007, 16'h0300});
    do_reset();
    run('{8'h09, 8'h31, 8'h0A, 8'h2B, 8'h0D, 8'h00}, 0, 200);
    expect_tokens("ctrl_ws", got0, '{16'h0001, 16'h0100, 16'h0300});
  endtask

  task automatic test_saturate();
    do_reset();
    run(str2q("300~"), 1, 200);
    expect_tokens("wrap_300", got0, '{16'h002C, 16'h0300});
    expect_tokens("sat_300", got1, '{16'h00FF, 16'h0300});
    do_reset();
    run(str2q("255+256*99999~"), 0, 300);
    expect_tokens("wrap_edge", got0, '{16'h00FF, 16'h0100, 16'h0000, 16'h0200, 16'h009F, 16'h0300});
    expect_tokens("sat_edge", got1, '{16'h00FF, 16'h0100, 16'h00FF, 16'h0200, 16'h00FF, 16'h0300});
  endtask

  task automatic test_error();
    do_reset();
    run(str2q("1-5+~"), 0, 100);
    expect_tokens("err_no_num", got0, '{});
    checks++;
    if (err0 !== 1'b1 || vld0 !== 1'b0 || rdy0 !== 1'b0) begin
      failures++; $display("FAIL err_sticky: err/vld/rdy=%b, want 100", {err0, vld0, rdy0});
    end
  endtask

  task automatic test_hold();
    do_reset();
    run(str2q("+~"), 20, 200);
    expect_tokens("hold", got0, '{16'h0100, 16'h0300});
  endtask

  task automatic test_async_reset();
    do_reset();
    I_VALID = 1'b1; I_CHAR = 8'h34;
    @(negedge CLK);
    I_VALID = 1'b0;
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({rdy0, vld0, tok0, err0, rdy1, vld1, tok1, err1} !== '0) begin
      failures++; $display("FAIL async_reset: got %b, want all 0", {rdy0, vld0, tok0, err0, rdy1, vld1, tok1, err1});
    end
    @(negedge CLK); RST = 1'b1;
    run(str2q("5~"), 1, 100);
    expect_tokens("after_async", got0, '{16'h0005, 16'h0300});
    do_reset();
    run(str2q("1+2*3~"), 2, 200);
    expect_tokens("parser_input", got0, '{16'h0001, 16'h0100, 16'h0002, 16'h0200, 16'h0003, 16'h0300});
  endtask

  task automatic test_back_to_back();
    tq_t e0, e1;
    bit e;
    bq_t q;
    q = str2q("1*2+33 + 4*~");
    model(q, 0, e0, e);
    model(q, 1, e1, e);
    do_reset();
    run(q, 0, 300);
    expect_tokens("b2b", got0, e0);
  endtask

  task automatic test_random();
    logic [7:0] ill[4] = '{8'h2D, 8'h61, 8'h2F, 8'hFF};
    logic [7:0] ws[4]  = '{8'h20, 8'h09, 8'h0A, 8'h0D};
    bq_t q;
    tq_t e0, e1;
    bit e, ed;
    int r;
    for (int it = 0; it < 40; it++) begin
      q = {};
      for (int s = 0; s < $urandom_range(1, 8); s++) begin
        r = $urandom_range(0, 9);
        if (r <= 4) begin
          for (int d = 0; d < $urandom_range(1, 4); d++) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
        end else if (r <= 6) q.push_back($urandom_range(0, 1) ? 8'h2B : 8'h2A);
        else if (r <= 8) q.push_back(ws[$urandom_range(0, 3)]);
        else if ($urandom_range(0, 2) == 0) q.push_back(ill[$urandom_range(0, 3)]);
      end
      q.push_back(8'h00);
      q.push_back(8'h39);
      model(q, 0, e0, e);
      model(q, 1, e1, ed);
      do_reset();
      run(q, $urandom_range(0, 3), q.size() * 12 + 60);
      expect_tokens("rand_wrap", got0, e0);
      expect_tokens("rand_sat", got1, e1);
      checks++;
      if (err0 !== e) begin
        failures++; $display("FAIL rand_error: ERROR=%b, want %b (iter %0d)", err0, e, it);
      end
    end
  endtask

  initial begin
    test_reset();
    test_expression();
    test_whitespace();
    test_saturate();
    test_error();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
